sys_arr_feeder: RTL and testbench

//  Upstream stage of sys_arr. Captures full MxM operand matrices A and B in one

---
 rtl/sys_arr_feeder.sv | 78 +++++++
 tb/tb_sys_arr_feeder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: capture MxM A/B operands and stream them diagonally skewed, zero-padded and flushed into sys_arr
module sys_arr_feeder #(
  parameter int M = 3,
  parameter int FLUSH_BEATS = M
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [M-1:0][M-1:0][7:0]  mat_a,
  input  logic [M-1:0][M-1:0][7:0]  mat_b,
  output logic                      arr_vld,
  input  logic                      arr_rdy,
  output logic [M-1:0][7:0]         a_out,
  output logic [M-1:0][7:0]         b_out,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(3*M-2+FLUSH_BEATS)+1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t st, st_n;
  logic [CW-1:0] t, t_n;
  logic [M-1:0][M-1:0][7:0] ma, mb, ma_n, mb_n;
  logic [M-1:0][7:0] a_n, b_n;
  logic acc, last_d, last_f, done_n;
  assign acc = arr_vld & arr_rdy;
  assign last_d = t == CW'(3*M-3);
  assign last_f = t == CW'(FLUSH_BEATS-1);
  assign in_rdy = st == IDLE;
  assign busy = st != IDLE;
  always_ff @(posedge CLK) begin
    ma <= ma_n;
    mb <= mb_n;
    if (rst) begin
      st <= IDLE;
      t <= '0;
      arr_vld <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      t <= t_n;
      arr_vld <= st_n != IDLE;
      a_out <= a_n;
      b_out <= b_n;
      done <= done_n;
    end
  end
  always_comb begin
    st_n = st;
    t_n = t;
    done_n = 1'b0;
    if (st == IDLE && in_vld) begin
      st_n = STREAM;
      t_n = '0;
    end else if (st == STREAM && acc) begin
      st_n = last_d ? FLUSH : STREAM;
      t_n = last_d ? '0 : t + 1'b1;
    end else if (st == FLUSH && acc) begin
      st_n = last_f ? IDLE : FLUSH;
      t_n = last_f ? '0 : t + 1'b1;
      done_n = last_f;
    end
  end
  always_comb begin
    ma_n = (st == IDLE && in_vld) ? mat_a : ma;
    mb_n = (st == IDLE && in_vld) ? mat_b : mb;
    a_n = '0;
    b_n = '0;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++)
        if (st_n == STREAM && t_n == CW'(i+k)) begin
          a_n[i] = ma_n[i][k];
          b_n[i] = mb_n[k][i];
        end
  end
endmodule

// File: tb/tb_sys_arr_feeder.sv
// tb_sys_arr_feeder: directed self-checking bench for sys_arr_feeder (M=3 and M=4)
module tb_sys_arr_feeder;
  logic CLK = 1'b0, rst, in_vld, in_vld4, arr_rdy;
  logic [2:0][2:0][7:0] mat_a, mat_b;
  logic [3:0][3:0][7:0] mat_a4, mat_b4;
  logic in_rdy, arr_vld, busy, done, in_rdy4, arr_vld4, busy4, done4;
  logic [2:0][7:0] a_out, b_out;
  logic [3:0][7:0] a_out4, b_out4;
  int passed = 0, failed = 0, total = 0, cyc, seen;
  logic [23:0] ea [7] = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000, 24'h0, 24'h0};
  logic [23:0] eb [7] = '{24'h000001, 24'h0, 24'h000100, 24'h0, 24'h010000, 24'h0, 24'h0};
  always #5 CLK = ~CLK;
  sys_arr_feeder #(.M(3)) u3 (.CLK(CLK), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .mat_a(mat_a), .mat_b(mat_b),
    .arr_vld(arr_vld), .arr_rdy(arr_rdy), .a_out(a_out), .b_out(b_out), .busy(busy), .done(done));
  sys_arr_feeder #(.M(4)) u4 (.CLK(CLK), .rst(rst), .in_vld(in_vld4), .in_rdy(in_rdy4), .mat_a(mat_a4), .mat_b(mat_b4),
    .arr_vld(arr_vld4), .arr_rdy(arr_rdy), .a_out(a_out4), .b_out(b_out4), .busy(busy4), .done(done4));
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_ai;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        mat_a[r][c] = 8'(3*r+c+1);
        mat_b[r][c] = (r == c) ? 8'd1 : 8'd0;
      end
  endtask
  initial begin
    rst = 1'b1; in_vld = 1'b0; in_vld4 = 1'b0; arr_rdy = 1'b1;
    mat_a = '0; mat_b = '0; mat_a4 = '0; mat_b4 = '0;
    step; step;
    chk("rst_vld", 64'(arr_vld), 64'(1'b0));
    chk("rst_a", 64'(a_out), 64'(24'h0));
    chk("rst_b", 64'(b_out), 64'(24'h0));
    chk("rst_done", 64'(done), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(1'b1));
    rst = 1'b0;
    set_ai;
    in_vld = 1'b1;
    step;
    in_vld = 1'b0;
    chk("t1_busy", 64'(busy), 64'(1'b1));
    chk("t1_in_rdy", 64'(in_rdy), 64'(1'b0));
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("t1_a%0d", t), 64'(a_out), 64'(ea[t]));
      chk($sformatf("t1_b%0d", t), 64'(b_out), 64'(eb[t]));
      chk($sformatf("t1_vld%0d", t), 64'(arr_vld), 64'(1'b1));
      step;
    end
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("t1_flush_a%0d", f), 64'(a_out), 64'(24'h0));
      chk($sformatf("t1_flush_vld%0d", f), 64'(arr_vld), 64'(1'b1));
      chk($sformatf("t1_flush_done%0d", f), 64'(done), 64'(1'b0));
      step;
    end
    chk("t1_done", 64'(done), 64'(1'b1));
    chk("t1_end_vld", 64'(arr_vld), 64'(1'b0));
    chk("t1_end_busy", 64'(busy), 64'(1'b0));
    chk("t1_end_in_rdy", 64'(in_rdy), 64'(1'b1));
    in_vld = 1'b1;
    step;
    in_vld = 1'b0;
    chk("t2_beat0_a", 64'(a_out), 64'(24'h000001));
    step; step;
    chk("t2_beat2_a", 64'(a_out), 64'(24'h070503));
    arr_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step;
      chk($sformatf("t2_hold_a%0d", s), 64'(a_out), 64'(24'h070503));
      chk($sformatf("t2_hold_vld%0d", s), 64'(arr_vld), 64'(1'b1));
    end
    arr_rdy = 1'b1;
    step;
    chk("t2_beat3_a", 64'(a_out), 64'(24'h080600));
    cyc = 8;
    while (!done && cyc < 40) begin
      step;
      cyc++;
    end
    chk("t2_done_cycle", 64'(cyc), 64'(15));
    in_vld = 1'b1;
    step;
    mat_a = {9{8'hAA}};
    mat_b = {9{8'h55}};
    chk("t4_beat0_a", 64'(a_out), 64'(24'h000001));
    step; step;
    chk("t4_beat2_a", 64'(a_out), 64'(24'h070503));
    chk("t4_beat2_b", 64'(b_out), 64'(24'h000100));
    chk("t4_in_rdy", 64'(in_rdy), 64'(1'b0));
    step; step;
    chk("t4_beat4_a", 64'(a_out), 64'(24'h090000));
    chk("t4_beat4_b", 64'(b_out), 64'(24'h010000));
    repeat (6) step;
    chk("t4_done", 64'(done), 64'(1'b1));
    step;
    in_vld = 1'b0;
    chk("t4_reload_a", 64'(a_out), 64'(24'h0000AA));
    chk("t4_reload_b", 64'(b_out), 64'(24'h000055));
    chk("t4_reload_done", 64'(done), 64'(1'b0));
    chk("t4_reload_vld", 64'(arr_vld), 64'(1'b1));
    step; step; step;
    chk("t3_beat3_a", 64'(a_out), 64'(24'hAAAA00));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t3_vld", 64'(arr_vld), 64'(1'b0));
    chk("t3_a", 64'(a_out), 64'(24'h0));
    chk("t3_b", 64'(b_out), 64'(24'h0));
    chk("t3_in_rdy", 64'(in_rdy), 64'(1'b1));
    chk("t3_busy", 64'(busy), 64'(1'b0));
    seen = 0;
    repeat (15) begin
      step;
      if (done || busy) seen = 1;
    end
    chk("t3_no_done", 64'(seen), 64'(0));
    mat_a4 = {16{8'hFF}};
    mat_b4 = {16{8'hFF}};
    in_vld4 = 1'b1;
    step;
    in_vld4 = 1'b0;
    chk("t6_beat0_a", 64'(a_out4), 64'(32'h000000FF));
    chk("t6_beat0_b", 64'(b_out4), 64'(32'h000000FF));
    step; step; step;
    chk("t6_beat3_a", 64'(a_out4), 64'(32'hFFFFFFFF));
    chk("t6_beat3_b", 64'(b_out4), 64'(32'hFFFFFFFF));
    cyc = 4;
    while (!done4 && cyc < 60) begin
      step;
      cyc++;
    end
    chk("t6_done_cycle", 64'(cyc), 64'(15));
    chk("t6_end_vld", 64'(arr_vld4), 64'(1'b0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
